// File: rtl/uart_block_assembler.sv
// Packs bytes from the UART receiver into one NBYTES-wide AES input block and hands it off over valid/ready.
// Inter-byte timeout that discards partial blocks is compiled in only when UART_ASM_TIMEOUT_EN is defined.
module uart_block_assembler #(
  parameter int NBYTES         = 16,
  parameter int CW             = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                RxDone,
  input  logic [7:0]          RxData,
  input  logic                Clear,
  input  logic                BlkReady,
  output logic [8*NBYTES-1:0] BlkData,
  output logic                BlkValid,
  output logic [CW-1:0]       ByteCount,
  output logic                Overrun,
  output logic                TimeoutErr
);

  // state   | meaning
  // COLLECT | shifting received bytes into the current block
  // HOLD    | block complete and frozen until BlkReady; new bytes are dropped as overrun
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int            BW       = 8 * NBYTES;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  if (NBYTES < 1 || CW < $clog2(NBYTES + 1) || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("uart_block_assembler: invalid parameter set");
  end

  state_t        state, state_nxt;
  logic          rx_s1, rx_s2, rx_s3;
  logic          byte_evt;
  logic [BW-1:0] shifted;
  logic [BW-1:0] data_nxt;
  logic          valid_nxt;
  logic [CW-1:0] count_nxt;
  logic          ovr_nxt;
  logic          tmo_nxt;
  logic          tmo_hit;

  // RxDone is asynchronous; RxData is trusted to be stable by the time the event fires.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= RxDone;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign byte_evt = rx_s2 & ~rx_s3;
  assign shifted  = (BlkData << 8) | BW'(RxData);

`ifdef UART_ASM_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;

  // A byte landing on the expiry edge wins over the timeout.
  assign tmo_hit = (state == COLLECT) && (ByteCount != '0) && !byte_evt && !Clear &&
                   (tmo_cnt == TMO_LAST);

  always_comb begin
    tmo_cnt_nxt = tmo_cnt + TW'(1);
    if (Clear || byte_evt || tmo_hit || (state == HOLD) || (ByteCount == '0)) begin
      tmo_cnt_nxt = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    data_nxt  = BlkData;
    valid_nxt = BlkValid;
    count_nxt = ByteCount;
    ovr_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    if (Clear) begin
      // BlkData is intentionally left alone; only the fill level is discarded.
      state_nxt = COLLECT;
      valid_nxt = 1'b0;
      count_nxt = '0;
    end else begin
      case (state)
        COLLECT: begin
          if (byte_evt) begin
            data_nxt  = shifted;
            count_nxt = ByteCount + ONE;
            if (ByteCount == LAST_IDX) begin
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end else if (tmo_hit) begin
            count_nxt = '0;
            tmo_nxt   = 1'b1;
          end
        end
        HOLD: begin
          if (BlkReady) begin
            valid_nxt = 1'b0;
            count_nxt = '0;
            state_nxt = COLLECT;
            if (byte_evt) begin
              data_nxt  = shifted;
              count_nxt = ONE;
              if (LAST_IDX == '0) begin
                valid_nxt = 1'b1;
                state_nxt = HOLD;
              end
            end
          end else if (byte_evt) begin
            ovr_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = COLLECT;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= COLLECT;
      BlkData    <= '0;
      BlkValid   <= 1'b0;
      ByteCount  <= '0;
      Overrun    <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      state      <= state_nxt;
      BlkData    <= data_nxt;
      BlkValid   <= valid_nxt;
      ByteCount  <= count_nxt;
      Overrun    <= ovr_nxt;
      TimeoutErr <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_uart_block_assembler.sv
// Self-checking bench for uart_block_assembler: directed scenarios plus random traffic
// compared every cycle against a byte-queue reference model.
module tb_uart_block_assembler;

  localparam int NB  = 16;
  localparam int TMO = 100;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         RxDone;
  logic [7:0]   RxData;
  logic         Clear;
  logic         BlkReady;
  logic [127:0] BlkData;
  logic         BlkValid;
  logic [4:0]   ByteCount;
  logic         Overrun;
  logic         TimeoutErr;

  int checks   = 0;
  int errors   = 0;
  int ovr_seen = 0;
  int tmo_seen = 0;

  uart_block_assembler #(
    .NBYTES(NB),
    .CW(5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .RxDone(RxDone),
    .RxData(RxData),
    .Clear(Clear),
    .BlkReady(BlkReady),
    .BlkData(BlkData),
    .BlkValid(BlkValid),
    .ByteCount(ByteCount),
    .Overrun(Overrun),
    .TimeoutErr(TimeoutErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the current block is a queue of bytes; a byte event is the third
  // rising edge after RxDone is seen to rise.
  logic [7:0] mq[$];
  bit         m_valid, m_ovr, m_tmo, rxd_prev;
  int         age, idle;

  always @(posedge Clk or negedge Rst_n) begin
    bit evt;
    if (!Rst_n) begin
      mq.delete();
      m_valid  = 0;
      m_ovr    = 0;
      m_tmo    = 0;
      rxd_prev = 0;
      age      = 0;
      idle     = 0;
    end else begin
      evt = (age == 2);
      if (RxDone && !rxd_prev) age = 1;
      else if (age == 1)       age = 2;
      else                     age = 0;
      rxd_prev = RxDone;
      m_ovr = 0;
      m_tmo = 0;
      if (Clear) begin
        mq.delete();
        m_valid = 0;
        idle    = 0;
      end else if (m_valid) begin
        idle = 0;
        if (BlkReady) begin
          mq.delete();
          m_valid = 0;
          if (evt) mq.push_back(RxData);
        end else if (evt) begin
          m_ovr = 1;
        end
      end else if (evt) begin
        mq.push_back(RxData);
        idle = 0;
        if (mq.size() == NB) m_valid = 1;
      end else if (mq.size() > 0) begin
`ifdef UART_ASM_TIMEOUT_EN
        idle++;
        if (idle == TMO) begin
          mq.delete();
          idle  = 0;
          m_tmo = 1;
        end
`endif
      end else begin
        idle = 0;
      end
    end
  end

  always @(negedge Clk) begin
    logic [127:0] e;
    logic [127:0] m;
    e = '0;
    m = '0;
    foreach (mq[i]) begin
      e = (e << 8) | 128'(mq[i]);
      m = (m << 8) | 128'hFF;
    end
    check("count", 128'(ByteCount), 128'(mq.size()));
    check("valid", 128'(BlkValid), 128'(m_valid));
    check("overrun", 128'(Overrun), 128'(m_ovr));
    check("timeout", 128'(TimeoutErr), 128'(m_tmo));
    check("data", BlkData & m, e);
    if (Overrun) ovr_seen++;
    if (TimeoutErr) tmo_seen++;
  end

  task automatic send_byte(input logic [7:0] b, input int hi, input int gap,
                           input bit rdy_cap, input bit rand_ctl);
    @(negedge Clk);
    RxData   = b;
    RxDone   = 1'b1;
    BlkReady = 1'b0;
    Clear    = 1'b0;
    repeat (2) @(negedge Clk);
    if (rdy_cap) BlkReady = 1'b1;
    @(negedge Clk);
    if (rdy_cap) BlkReady = 1'b0;
    repeat (hi - 3) @(negedge Clk);
    RxDone = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge Clk);
      if (rand_ctl) begin
        BlkReady = ($urandom_range(0, 3) == 0);
        Clear    = ($urandom_range(0, 24) == 0);
      end
    end
  endtask

  task automatic flush();
    @(negedge Clk);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
  endtask

  task automatic handshake();
    @(negedge Clk);
    BlkReady = 1'b1;
    @(negedge Clk);
    BlkReady = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 Rst_n = 1'b0;
    #1;
    check({tag, "_data"}, BlkData, 128'h0);
    check({tag, "_valid"}, 128'(BlkValid), 128'h0);
    check({tag, "_count"}, 128'(ByteCount), 128'h0);
    check({tag, "_ovr"}, 128'(Overrun), 128'h0);
    check({tag, "_tmo"}, 128'(TimeoutErr), 128'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_blk;
    logic [7:0]   b;
    int           ov0, tm0;

    Rst_n    = 1'b0;
    RxDone   = 1'b0;
    RxData   = 8'h00;
    Clear    = 1'b0;
    BlkReady = 1'b0;
    #23;
    check("rst_data", BlkData, 128'h0);
    check("rst_valid", 128'(BlkValid), 128'h0);
    check("rst_count", 128'(ByteCount), 128'h0);
    check("rst_ovr", 128'(Overrun), 128'h0);
    check("rst_tmo", 128'(TimeoutErr), 128'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Ascending block, consumer stalled
    for (int i = 0; i < NB; i++) send_byte(8'(i), 3, 4, 1'b0, 1'b0);
    check("blk0_valid", 128'(BlkValid), 128'h1);
    check("blk0_count", 128'(ByteCount), 128'd16);
    check("blk0_data", BlkData, 128'h000102030405060708090A0B0C0D0E0F);

    // Byte while held is dropped
    ov0 = ovr_seen;
    send_byte(8'h55, 4, 4, 1'b0, 1'b0);
    check("ovr_pulses", 128'(ovr_seen - ov0), 128'd1);
    check("ovr_data", BlkData, 128'h000102030405060708090A0B0C0D0E0F);

    // Handshake and new byte on the same edge
    send_byte(8'h77, 4, 4, 1'b1, 1'b0);
    check("hs_valid", 128'(BlkValid), 128'h0);
    check("hs_count", 128'(ByteCount), 128'd1);
    check("hs_low", 128'(BlkData[7:0]), 128'h77);

    // Long RxDone pulse yields one byte
    send_byte(8'hA5, 50, 4, 1'b0, 1'b0);
    check("long_count", 128'(ByteCount), 128'd2);
    check("long_low", 128'(BlkData[15:0]), 128'h77A5);

    // Clear after a partial block, then a full block
    flush();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 3, 4, 1'b0, 1'b0);
    ov0 = ovr_seen;
    tm0 = tmo_seen;
    flush();
    check("clr_count", 128'(ByteCount), 128'h0);
    check("clr_valid", 128'(BlkValid), 128'h0);
    exp_blk = '0;
    for (int i = 0; i < NB; i++) begin
      b = 8'($urandom);
      exp_blk = (exp_blk << 8) | 128'(b);
      send_byte(b, $urandom_range(3, 6), $urandom_range(3, 6), 1'b0, 1'b0);
    end
    check("clr_blk_data", BlkData, exp_blk);
    check("clr_blk_valid", 128'(BlkValid), 128'h1);
    check("clr_no_ovr", 128'(ovr_seen - ov0), 128'h0);
    check("clr_no_tmo", 128'(tmo_seen - tm0), 128'h0);
    handshake();
    check("clr_hs_valid", 128'(BlkValid), 128'h0);

`ifdef UART_ASM_TIMEOUT_EN
    flush();
    tm0 = tmo_seen;
    send_byte(8'h11, 3, 4, 1'b0, 1'b0);
    send_byte(8'h22, 3, 4, 1'b0, 1'b0);
    send_byte(8'h33, 3, 150, 1'b0, 1'b0);
    check("tmo_pulses", 128'(tmo_seen - tm0), 128'd1);
    check("tmo_count", 128'(ByteCount), 128'h0);
    tm0 = tmo_seen;
    send_byte(8'h44, 3, 4, 1'b0, 1'b0);
    send_byte(8'h55, 3, 4, 1'b0, 1'b0);
    send_byte(8'h66, 4, 95, 1'b0, 1'b0);
    send_byte(8'h88, 3, 4, 1'b0, 1'b0);
    check("tmo_race_pulses", 128'(tmo_seen - tm0), 128'h0);
    check("tmo_race_count", 128'(ByteCount), 128'd4);
    check("tmo_race_data", 128'(BlkData[31:0]), 128'h44556688);
    flush();
`endif

    // Asynchronous reset mid-block and mid-HOLD
    flush();
    for (int i = 0; i < 9; i++) send_byte(8'(8'hC0 + i), 3, 4, 1'b0, 1'b0);
    check("pre_rst_count", 128'(ByteCount), 128'd9);
    async_reset_check("rst_mid");
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), 3, 4, 1'b0, 1'b0);
    check("pre_rst_hold", 128'(BlkValid), 128'h1);
    async_reset_check("rst_hold");
    exp_blk = '0;
    for (int i = 0; i < NB; i++) begin
      b = 8'(i * 17 + 3);
      exp_blk = (exp_blk << 8) | 128'(b);
      send_byte(b, 3, 4, 1'b0, 1'b0);
    end
    check("post_rst_data", BlkData, exp_blk);
    check("post_rst_valid", 128'(BlkValid), 128'h1);
    handshake();

    // Random traffic with random consumer stalls and flushes
    for (int n = 0; n < 120; n++) begin
      send_byte(8'($urandom), $urandom_range(3, 8), $urandom_range(3, 8), 1'b0, 1'b1);
    end
    @(negedge Clk);
    BlkReady = 1'b0;
    Clear    = 1'b0;
    repeat (5) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_block_assembler.md
Name: uart_block_assembler

Overview:
- Sits directly downstream of the UART receiver.
- Collects received bytes, signalled by RxDone with RxData, into one AES-128 input block of NBYTES bytes.
- Presents the finished block to the AES core over a valid/ready handshake.
- Also handles RxDone synchronisation/edge detection, overrun on a stalled consumer, inter-byte timeout and synchronous flush.

Parameters:
- NBYTES, 16, bytes per block; BlkData width = 8*NBYTES.
- CW, 5, width of ByteCount; must hold values 0..NBYTES.
- TIMEOUT_CYCLES, 1000000, Clk cycles of inter-byte silence before a partial block is discarded (used only with UART_ASM_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock; all logic rises on posedge Clk.
- Rst_n  in  1  asynchronous, active-low reset.
- RxDone  in  1  byte-complete flag from the receiver; may stay high for many Clk cycles; asynchronous to Clk.
- RxData  in  8  received byte; stable while RxDone is high.
- Clear  in  1  synchronous flush, highest priority.
- BlkReady  in  1  consumer accepts the block.
- BlkData  out  8*NBYTES  assembled block; first byte received sits in [8*NBYTES-1 -: 8].
- BlkValid  out  1  block complete and held.
- ByteCount  out  CW  bytes collected in the current block.
- Overrun  out  1  one-cycle pulse: byte dropped because a block was held.
- TimeoutErr  out  1  one-cycle pulse: partial block discarded on timeout.

Behaviour:
- Reset (async, Rst_n=0):
  - BlkData=0, BlkValid=0, ByteCount=0, Overrun=0, TimeoutErr=0.
  - Sync flops = 0; state = COLLECT; timeout counter = 0.
- RxDone input path:
  - Two-flop synchroniser s1→s2, then a third flop s3.
  - byte_evt = s2 & ~s3. Exactly one event per RxDone rising edge, however long RxDone stays high.
  - A byte is captured on the 3rd rising Clk edge after RxDone rises.
  - RxData is sampled directly on that edge; no extra synchronisation.
- State COLLECT:
  - On byte_evt: BlkData <= {BlkData[8*NBYTES-9:0], RxData}; ByteCount <= ByteCount+1.
  - If ByteCount was NBYTES-1: ByteCount becomes NBYTES, BlkValid <= 1, go to HOLD. This happens on the same edge as the last byte capture, so latency = 3 Clk from the last RxDone rise.
- State HOLD:
  - BlkData and ByteCount are frozen; BlkValid stays 1 until BlkValid & BlkReady.
  - On the handshake edge: BlkValid <= 0, ByteCount <= 0, go to COLLECT.
  - byte_evt on the handshake edge: the byte is accepted as byte 0 of the new block (ByteCount <= 1, BlkData shifts).
  - byte_evt in HOLD without a handshake: byte dropped, Overrun=1 for one cycle, block untouched.
- BlkReady while BlkValid=0 is ignored.
- Clear=1: ByteCount <= 0, BlkValid <= 0, state COLLECT, timeout counter cleared.
  - Any byte_evt on the same edge is discarded without Overrun.
  - BlkData is not cleared.
- BlkData content below the filled bytes is don't-care while ByteCount < NBYTES.
- ByteCount never exceeds NBYTES.

Optional Feature:
- Macro UART_ASM_TIMEOUT_EN.
- Defined:
  - In COLLECT with ByteCount>0, a counter increments each Clk and is cleared on every byte_evt.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte_evt on that edge: ByteCount <= 0, counter <= 0, TimeoutErr=1 for one cycle.
  - byte_evt on that same edge wins: the byte is accepted and there is no timeout.
  - The counter is held at 0 in HOLD and when ByteCount=0.
- Undefined: no counter logic; TimeoutErr tied to 0; partial blocks wait indefinitely.

Test Plan:
- Reset, then send 16 bytes 0x00..0x0F, BlkReady=0:
  - BlkValid=1 exactly 3 Clk after the 16th RxDone rise.
  - BlkData=128'h000102030405060708090A0B0C0D0E0F; ByteCount=16.
- Hold RxDone high 50 Clk for a single byte 0xA5 → ByteCount increments by exactly 1; BlkData[7:0]=0xA5.
- Block held, 17th byte 0x55 with BlkReady=0 → one-cycle Overrun pulse; BlkData unchanged.
  - Then BlkReady=1 with a byte 0x77 event on the same edge → BlkValid=0, ByteCount=1, BlkData[7:0]=0x77.
- 5 bytes collected, then Clear=1 for 1 cycle → ByteCount=0, BlkValid=0, no Overrun/TimeoutErr.
  - Next 16 bytes form a correct block.
- With UART_ASM_TIMEOUT_EN and TIMEOUT_CYCLES=100: 3 bytes, then silence → TimeoutErr pulse 100 Clk after the 3rd capture; ByteCount=0.
  - A byte_evt landing exactly on the expiry edge → no TimeoutErr; ByteCount=4.
- Assert Rst_n=0 mid-block (ByteCount=9) and mid-HOLD, asynchronously between edges → all outputs at reset values immediately.
  - A subsequent 16-byte block assembles correctly.
